// File: rtl/lab2_problem2_pkg.sv
// lab2_problem2_pkg
//   Shared definitions for the lab2_problem2 registered ALU: the 3-bit
//   opcode encoding and the default operand width.
package lab2_problem2_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

endpackage

// File: rtl/lab2_alu_core.sv
// lab2_alu_core
//   Purely combinational ALU datapath.
//   Ports:
//     Select - 3-bit opcode (see op_e)
//     A, B   - WIDTH-bit unsigned operands
//     C      - carry-in for ADD/SUB, shift-in bit for SHL/SHR
//     result - WIDTH-bit result
//     carry  - carry-out (ADD/SUB), shifted-out bit (SHL/SHR), 0 otherwise
module lab2_alu_core
    import lab2_problem2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       Select,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // One extra bit so the adder's MSB falls out as the carry.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] cin_ext;

    assign cin_ext = {{WIDTH{1'b0}}, C};

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op_e'(Select))
            OP_ADD: begin
                sum    = {1'b0, A} + {1'b0, B} + cin_ext;
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            // Subtract as A + ~B + C: C=1 is "no borrow-in" and a carry
            // out of the top means "no borrow-out".
            OP_SUB: begin
                sum    = {1'b0, A} + {1'b0, ~B} + cin_ext;
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_AND: result = A & B;
            OP_OR:  result = A | B;
            OP_XOR: result = A ^ B;
            OP_NOT: result = ~A;
            OP_SHL: begin
                result = {A[WIDTH-2:0], C};
                carry  = A[WIDTH-1];
            end
            OP_SHR: begin
                result = {C, A[WIDTH-1:1]};
                carry  = A[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lab2_problem2.sv
// lab2_problem2
//   Registered ALU: the combinational core result is captured every rising
//   edge, giving exactly one cycle of latency and no handshake.
//   Ports:
//     clock    - single clock, rising edge
//     reset    - synchronous active-low reset; clears RegOut/Carryout
//     Select   - 3-bit opcode
//     A, B     - WIDTH-bit unsigned operands
//     C        - carry-in / shift-in bit
//     RegOut   - registered result
//     Carryout - registered carry / shift-out flag
module lab2_problem2
    import lab2_problem2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       Select,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] RegOut,
    output logic             Carryout
);

    logic [WIDTH-1:0] RegOut_d, RegOut_q;
    logic             Carryout_d, Carryout_q;

    lab2_alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .Select (Select),
        .A      (A),
        .B      (B),
        .C      (C),
        .result (RegOut_d),
        .carry  (Carryout_d)
    );

    // Reset wins over the operation in the same cycle; releasing it has no
    // recovery latency since the next edge just loads the core output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            RegOut_q   <= '0;
            Carryout_q <= 1'b0;
        end else begin
            RegOut_q   <= RegOut_d;
            Carryout_q <= Carryout_d;
        end
    end

    assign RegOut   = RegOut_q;
    assign Carryout = Carryout_q;

endmodule

// File: tb/tb_lab2_problem2.sv
module tb_lab2_problem2;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clock;
    logic         reset;
    logic [2:0]   Select;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C;
    logic [W-1:0] RegOut;
    logic         Carryout;

    int errors = 0;
    int checks = 0;

    lab2_problem2 #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .Select   (Select),
        .A        (A),
        .B        (B),
        .C        (C),
        .RegOut   (RegOut),
        .Carryout (Carryout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: integer arithmetic straight from the operation table.
    task automatic model(input int rst, input int sel, input int a, input int b,
                         input int c, output int ro, output int co);
        int t;
        ro = 0;
        co = 0;
        if (rst == 0) return;
        case (sel)
            0: begin t = a + b + c;               ro = t % MOD; co = t / MOD; end
            1: begin t = a + (MOD - 1 - b) + c;   ro = t % MOD; co = t / MOD; end
            2: ro = a & b;
            3: ro = a | b;
            4: ro = a ^ b;
            5: ro = (MOD - 1) - a;
            6: begin ro = (a * 2 + c) % MOD;      co = a / (MOD / 2); end
            default: begin ro = c * (MOD / 2) + a / 2; co = a % 2; end
        endcase
    endtask

    task automatic chk(input string tag, input int ro_exp, input int co_exp);
        logic [W-1:0] ro_e;
        logic         co_e;
        ro_e = ro_exp[W-1:0];
        co_e = co_exp[0];
        checks++;
        assert (RegOut === ro_e && Carryout === co_e)
        else begin
            errors++;
            $error("FAIL %s: got RegOut=%h Carryout=%b, expected RegOut=%h Carryout=%b",
                   tag, RegOut, Carryout, ro_e, co_e);
        end
    endtask

    // Drive one operation, clock it in, and compare against the model
    // (or against an explicit expectation when ro_x >= 0).
    task automatic step(input string tag, input int rst, input int sel, input int a,
                        input int b, input int c, input int ro_x, input int co_x);
        int ro, co;
        @(negedge clock);
        reset  = rst[0];
        Select = sel[2:0];
        A      = a[W-1:0];
        B      = b[W-1:0];
        C      = c[0];
        @(posedge clock);
        #1;
        model(rst, sel, a, b, c, ro, co);
        if (ro_x >= 0) begin
            ro = ro_x;
            co = co_x;
        end
        chk(tag, ro, co);
    endtask

    initial begin
        int ro, co;
        reset = 1'b0; Select = 3'd0; A = '0; B = '0; C = 1'b0;

        // Reset dominates an operation that would otherwise overflow.
        step("reset",     0, 0, 'hF, 'hF, 1, 0, 0);
        step("add_wrap",  1, 0, 'hF, 'h1, 0, 'h0, 1);
        step("add_cin",   1, 0, 'hF, 'h1, 1, 'h1, 1);
        step("sub_nobor", 1, 1, 'h5, 'h3, 1, 'h2, 1);
        step("sub_bor",   1, 1, 'h3, 'h5, 1, 'hE, 0);
        step("and",       1, 2, 'hC, 'hA, 0, 'h8, 0);
        step("or",        1, 3, 'hC, 'hA, 0, 'hE, 0);
        step("xor",       1, 4, 'hC, 'hA, 0, 'h6, 0);
        step("not",       1, 5, 'hC, 'hA, 0, 'h3, 0);
        step("shl",       1, 6, 'h9, 'h0, 1, 'h3, 1);
        step("shr",       1, 7, 'h9, 'h0, 0, 'h4, 1);

        // Input glitches between edges must not reach the outputs.
        @(negedge clock);
        Select = 3'd0; A = 4'hF; B = 4'hF; C = 1'b1;
        #1; Select = 3'd5; A = 4'h0;
        #1; chk("hold", 'h4, 1);
        @(posedge clock); #1;
        model(1, 5, 0, 'hF, 1, ro, co);
        chk("after_glitch", ro, co);

        // Exhaustive sweep with reset toggling every cycle; the second pass
        // flips the reset phase so every input combination is seen live.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4096; i++) begin
                step("sweep", (i + pass) % 2, (i >> 9) & 7, (i >> 5) & 15,
                     (i >> 1) & 15, i & 1, -1, 0);
            end
        end

        // Random back-to-back traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            step("random", ($urandom_range(0, 7) != 0) ? 1 : 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)),
                 int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 1)), -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab2_problem2.md
LAB2_PROBLEM2 -- requirements
Module: lab2_problem2

Interface
REQ-001 Parameter: WIDTH, default 4, data width of A, B and RegOut.
REQ-002 Port: clock, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: reset, input, 1, synchronous active-low reset; sampled only on rising clock.
REQ-004 Port: Select, input, 3, opcode choosing the ALU operation.
REQ-005 Port: A, input, WIDTH, operand A, unsigned.
REQ-006 Port: B, input, WIDTH, operand B, unsigned.
REQ-007 Port: C, input, 1, carry-in / shift-in bit.
REQ-008 Port: RegOut, output, WIDTH, registered ALU result.
REQ-009 Port: Carryout, output, 1, registered carry/shift-out flag.
REQ-010 The interface SHALL have one clock and a synchronous active-low reset, named clock and reset.

Function
REQ-011 The block SHALL compute the operation below combinationally from A, B, C and Select, and register the result.
  - 000 ADD: {Carryout,RegOut} = A + B + C.
  - 001 SUB: {Carryout,RegOut} = A + ~B + C; C=1 means no borrow-in; Carryout=1 means no borrow-out.
  - 010 AND: RegOut = A & B; Carryout = 0.
  - 011 OR: RegOut = A | B; Carryout = 0.
  - 100 XOR: RegOut = A ^ B; Carryout = 0.
  - 101 NOT: RegOut = ~A; Carryout = 0.
  - 110 SHL: RegOut = {A[WIDTH-2:0], C}; Carryout = A[WIDTH-1].
  - 111 SHR: RegOut = {C, A[WIDTH-1:1]}; Carryout = A[0].
REQ-012 Latency SHALL be exactly one cycle: inputs sampled at rising edge N appear on RegOut/Carryout after edge N.
REQ-013 Outputs SHALL hold their value between edges; there is no enable or handshake, and the block accepts a new operation every cycle.
REQ-014 Arithmetic SHALL be performed at WIDTH+1 bits; the MSB is Carryout; the result wraps modulo 2^WIDTH.
REQ-015 Combinational glitches on the inputs between edges SHALL NOT affect the outputs.
REQ-016 All 8 Select codes are defined; no X shall propagate for known inputs.

Reset
REQ-017 When reset=0 at a rising edge, RegOut SHALL become 0 and Carryout SHALL become 0, regardless of the other inputs.
REQ-018 Reset SHALL take priority over the operation in the same cycle. Reset may be asserted on any cycle, including alternating cycles, with no recovery latency: the first edge with reset=1 registers a normal result.
REQ-019 Before the first clock edge, the outputs are undefined. There is no asynchronous path.

Structure
REQ-020 A package lab2_problem2_pkg SHALL hold the 3-bit opcode enum (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR) and the default-width constant.
REQ-021 The combinational datapath SHALL be one sub-module, lab2_alu_core (A, B, C, Select -> result, carry). The top level SHALL hold only the output register and reset logic.

Verification
REQ-022 reset=0 with A=F, B=F, C=1, Select=000 for one edge -> RegOut=0, Carryout=0.
REQ-023 reset=1, Select=000, A=F, B=1, C=0 -> after one edge, RegOut=0, Carryout=1. With C=1 -> RegOut=1, Carryout=1.
REQ-024 Select=001, A=5, B=3, C=1 -> RegOut=2, Carryout=1. With A=3, B=5, C=1 -> RegOut=E, Carryout=0.
REQ-025 Logic ops with A=C, B=A (hex values): AND -> 8, OR -> E, XOR -> 6, NOT -> 3; Carryout=0 in every case.
REQ-026 Select=110, A=9, C=1 -> RegOut=3, Carryout=1. Select=111, A=9, C=0 -> RegOut=4, Carryout=1.
REQ-027 Exhaustive sweep of all 3+4+4+1 input bits, with reset toggling every cycle -> each non-reset cycle matches the reference model one edge later; each reset cycle yields 0/0.
